// File: rtl/microwave_power_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_power_ctrl
//  Description : Microwave oven controller. Takes keypad time entry and a
//                power level, counts down mm:ss in BCD and drives the
//                magnetron with a per-window duty cycle. Handles pause/resume,
//                the door interlock and a completion flag.
//                Optional feature macro: MW_QUICK_START_EN (start at 0:00
//                loads 0:30 and begins cooking).
//  Revision    : 1.0 - initial release
// ============================================================================
module microwave_power_ctrl #(
  parameter int MIN_DIGITS    = 1,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DUTY_WINDOW   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    clearn,
  input  logic                    door_closed,
  input  logic [9:0]              keypad,
  input  logic                    power_key,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] minutes,
  output logic [3:0]              power_level,
  output logic                    mag_on,
  output logic                    running,
  output logic                    done
);

  localparam int C_PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int C_WW = (DUTY_WINDOW > 1) ? $clog2(DUTY_WINDOW) : 1;
  localparam int C_MW = 4 * MIN_DIGITS;

  localparam logic [C_PW-1:0] c_TICK_LAST = C_PW'(TICKS_PER_SEC - 1);
  localparam logic [C_WW-1:0] c_WIN_LAST  = C_WW'(DUTY_WINDOW - 1);
  localparam logic [3:0]      c_PWR_MAX   = 4'(DUTY_WINDOW);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COOK   = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        sec_ones_q, sec_ones_d;
  logic [3:0]        sec_tens_q, sec_tens_d;
  logic [C_MW-1:0]   minutes_q, minutes_d;
  logic [3:0]        power_q, power_d;
  logic              arm_q, arm_d;
  logic [C_PW-1:0]   presc_q, presc_d;
  logic [C_WW-1:0]   window_q, window_d;
  logic              mag_q, mag_d;
  logic              startn_prev_q, startn_prev_d;
  logic              stopn_prev_q, stopn_prev_d;
  logic              clearn_prev_q, clearn_prev_d;
  logic              power_key_prev_q, power_key_prev_d;
  logic [9:0]        keypad_prev_q, keypad_prev_d;

  logic              w_start_ev, w_stop_ev, w_clear_ev, w_pk_ev, w_key_ev;
  logic              w_key_single;
  logic [3:0]        w_key_digit;
  logic              w_time_zero;
  logic [3:0]        w_dec_ones, w_dec_tens;
  logic [C_MW-1:0]   w_dec_min;
  logic              w_dec_zero;
  logic              w_borrow;
  logic [C_MW-1:0]   w_shift_min;

  // Edge events: each fires only on the first active cycle of an input.
  always_comb begin
    w_start_ev   = startn_prev_q & ~startn;
    w_stop_ev    = stopn_prev_q & ~stopn;
    w_clear_ev   = clearn_prev_q & ~clearn;
    w_pk_ev      = ~power_key_prev_q & power_key;
    w_key_single = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    w_key_ev     = (keypad_prev_q == 10'd0) && w_key_single;
    w_key_digit  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) w_key_digit = 4'(i);
    end
  end

  // One-second BCD decrement with borrow chain, plus the keypad shift-in value.
  always_comb begin
    w_dec_ones = sec_ones_q - 4'd1;
    w_dec_tens = sec_tens_q;
    w_dec_min  = minutes_q;
    w_borrow   = 1'b0;
    if (sec_ones_q == 4'd0) begin
      w_dec_ones = 4'd9;
      if (sec_tens_q != 4'd0) begin
        w_dec_tens = sec_tens_q - 4'd1;
      end else begin
        w_dec_tens = 4'd5;
        w_borrow   = 1'b1;
      end
    end
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (w_borrow) begin
        if (minutes_q[4*i +: 4] != 4'd0) begin
          w_dec_min[4*i +: 4] = minutes_q[4*i +: 4] - 4'd1;
          w_borrow            = 1'b0;
        end else begin
          w_dec_min[4*i +: 4] = 4'd9;
        end
      end
    end
    w_dec_zero  = (w_dec_ones == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_min == '0);
    w_time_zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (minutes_q == '0);

    // Top minute digit falls off; old sec_tens enters the lowest minute digit.
    w_shift_min = minutes_q;
    for (int i = 1; i < MIN_DIGITS; i++) begin
      w_shift_min[4*i +: 4] = minutes_q[4*(i-1) +: 4];
    end
    w_shift_min[3:0] = sec_tens_q;
  end

  // Next-state, time, power and counter logic in event-priority order.
  always_comb begin
    state_d          = state_q;
    sec_ones_d       = sec_ones_q;
    sec_tens_d       = sec_tens_q;
    minutes_d        = minutes_q;
    power_d          = power_q;
    arm_d            = arm_q;
    presc_d          = presc_q;
    window_d         = window_q;
    startn_prev_d    = startn;
    stopn_prev_d     = stopn;
    clearn_prev_d    = clearn;
    power_key_prev_d = power_key;
    keypad_prev_d    = keypad;

    if (w_clear_ev) begin
      state_d    = S_IDLE;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      minutes_d  = '0;
      power_d    = c_PWR_MAX;
      arm_d      = 1'b0;
      presc_d    = '0;
      window_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_start_ev) begin
            // A cook always begins with power entry disarmed.
            if (!w_time_zero && door_closed) begin
              state_d  = S_COOK;
              presc_d  = '0;
              window_d = '0;
              arm_d    = 1'b0;
            end
`ifdef MW_QUICK_START_EN
            else if (w_time_zero && door_closed) begin
              state_d    = S_COOK;
              sec_ones_d = 4'd0;
              sec_tens_d = 4'd3;
              presc_d    = '0;
              window_d   = '0;
              arm_d      = 1'b0;
            end
`endif
          end else begin
            if (w_key_ev) begin
              if (arm_q) begin
                power_d = (w_key_digit == 4'd0) ? c_PWR_MAX : w_key_digit;
                arm_d   = 1'b0;
              end else begin
                sec_ones_d = w_key_digit;
                sec_tens_d = sec_ones_q;
                minutes_d  = w_shift_min;
              end
            end
            if (w_pk_ev) arm_d = 1'b1;
          end
        end
        S_COOK: begin
          // Stop or door open freezes the partial second exactly where it is.
          if (w_stop_ev || !door_closed) begin
            state_d = S_PAUSED;
          end else if (presc_q == c_TICK_LAST) begin
            presc_d    = '0;
            window_d   = (window_q == c_WIN_LAST) ? '0 : window_q + 1'b1;
            sec_ones_d = w_dec_ones;
            sec_tens_d = w_dec_tens;
            minutes_d  = w_dec_min;
            if (w_dec_zero) state_d = S_DONE;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSED: begin
          if (w_stop_ev) begin
            state_d    = S_IDLE;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            minutes_d  = '0;
          end else if (w_start_ev && door_closed) begin
            state_d = S_COOK;
          end
        end
        S_DONE: begin
          if (!door_closed) begin
            state_d = S_IDLE;
          end else if (w_key_ev) begin
            state_d    = S_IDLE;
            sec_ones_d = w_key_digit;
            sec_tens_d = 4'd0;
            minutes_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Drive is computed from the post-edge state so it tracks running exactly.
    mag_d = (state_d == S_COOK) && (8'(window_d) < 8'(power_d));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      sec_ones_q       <= 4'd0;
      sec_tens_q       <= 4'd0;
      minutes_q        <= '0;
      power_q          <= c_PWR_MAX;
      arm_q            <= 1'b0;
      presc_q          <= '0;
      window_q         <= '0;
      mag_q            <= 1'b0;
      startn_prev_q    <= 1'b1;
      stopn_prev_q     <= 1'b1;
      clearn_prev_q    <= 1'b1;
      power_key_prev_q <= 1'b0;
      keypad_prev_q    <= 10'd0;
    end else begin
      state_q          <= state_d;
      sec_ones_q       <= sec_ones_d;
      sec_tens_q       <= sec_tens_d;
      minutes_q        <= minutes_d;
      power_q          <= power_d;
      arm_q            <= arm_d;
      presc_q          <= presc_d;
      window_q         <= window_d;
      mag_q            <= mag_d;
      startn_prev_q    <= startn_prev_d;
      stopn_prev_q     <= stopn_prev_d;
      clearn_prev_q    <= clearn_prev_d;
      power_key_prev_q <= power_key_prev_d;
      keypad_prev_q    <= keypad_prev_d;
    end
  end

  // The door gate is combinational so the magnetron drops in the same cycle.
  always_comb begin
    sec_ones    = sec_ones_q;
    sec_tens    = sec_tens_q;
    minutes     = minutes_q;
    power_level = power_q;
    mag_on      = mag_q & door_closed;
    running     = (state_q == S_COOK);
    done        = (state_q == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_microwave_power_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_microwave_power_ctrl
//  Description : Self-checking bench for microwave_power_ctrl. A driver pushes
//                the expected outputs of every cycle into a scoreboard queue
//                from an integer-arithmetic oven model; a monitor pops and
//                compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_microwave_power_ctrl;

  localparam int MD = 2;
  localparam int TPS = 4;
  localparam int DW = 10;

  localparam int M_IDLE = 0, M_COOK = 1, M_PAUSED = 2, M_DONE = 3;

  typedef struct packed {
    logic [3:0] so;
    logic [3:0] st;
    logic [7:0] mn;
    logic [3:0] pw;
    logic       mag;
    logic       run;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, startn, stopn, clearn, door_closed, power_key;
  logic [9:0] keypad;
  logic [3:0] sec_ones, sec_tens, power_level;
  logic [7:0] minutes;
  logic       mag_on, running, done;

  // staged stimulus for the next cycle
  logic       s_reset = 1'b1, s_startn = 1'b1, s_stopn = 1'b1, s_clearn = 1'b1;
  logic       s_door = 1'b1, s_pk = 1'b0;
  logic [9:0] s_keypad = 10'd0;

  // reference model state
  int  m_state, m_min, m_sec, m_pwr, m_sub, m_nsec;
  bit  m_arm, m_mag;
  bit  p_startn, p_stopn, p_clearn, p_pk;
  logic [9:0] p_key;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  microwave_power_ctrl #(
    .MIN_DIGITS(MD),
    .TICKS_PER_SEC(TPS),
    .DUTY_WINDOW(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startn(startn),
    .stopn(stopn),
    .clearn(clearn),
    .door_closed(door_closed),
    .keypad(keypad),
    .power_key(power_key),
    .sec_ones(sec_ones),
    .sec_tens(sec_tens),
    .minutes(minutes),
    .power_level(power_level),
    .mag_on(mag_on),
    .running(running),
    .done(done)
  );

  always #5 clk = ~clk;

  // Oven behaviour for one clock edge, using whole-number minutes and seconds.
  task automatic model_step();
    bit st_ev, sp_ev, cl_ev, k_ev, pk_ev;
    int d;
    if (s_reset) begin
      m_state = M_IDLE; m_min = 0; m_sec = 0; m_pwr = DW; m_arm = 0;
      m_sub = 0; m_nsec = 0; m_mag = 0;
      p_startn = 1; p_stopn = 1; p_clearn = 1; p_pk = 0; p_key = 10'd0;
      return;
    end
    st_ev = p_startn && !s_startn;
    sp_ev = p_stopn && !s_stopn;
    cl_ev = p_clearn && !s_clearn;
    pk_ev = !p_pk && s_pk;
    k_ev  = (p_key == 10'd0) && ($countones(s_keypad) == 1);
    d     = $clog2(s_keypad);
    if (cl_ev) begin
      m_state = M_IDLE; m_min = 0; m_sec = 0; m_pwr = DW; m_arm = 0;
      m_sub = 0; m_nsec = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (st_ev) begin
            if ((m_min != 0 || m_sec != 0) && s_door) begin
              m_state = M_COOK; m_sub = 0; m_nsec = 0; m_arm = 0;
            end
`ifdef MW_QUICK_START_EN
            else if (s_door) begin
              m_sec = 30; m_state = M_COOK; m_sub = 0; m_nsec = 0; m_arm = 0;
            end
`endif
          end else begin
            if (k_ev) begin
              if (m_arm) begin
                m_pwr = (d == 0) ? DW : d;
                m_arm = 0;
              end else begin
                m_min = (m_min * 10 + m_sec / 10) % (10 ** MD);
                m_sec = (m_sec % 10) * 10 + d;
              end
            end
            if (pk_ev) m_arm = 1;
          end
        end
        M_COOK: begin
          if (sp_ev || !s_door) m_state = M_PAUSED;
          else if (m_sub == TPS - 1) begin
            m_sub = 0;
            m_nsec++;
            if (m_sec > 0) m_sec--;
            else begin m_min--; m_sec = 59; end
            if (m_min == 0 && m_sec == 0) m_state = M_DONE;
          end else m_sub++;
        end
        M_PAUSED: begin
          if (sp_ev) begin m_state = M_IDLE; m_min = 0; m_sec = 0; end
          else if (st_ev && s_door) m_state = M_COOK;
        end
        default: begin
          if (!s_door) m_state = M_IDLE;
          else if (k_ev) begin m_state = M_IDLE; m_min = 0; m_sec = d; end
        end
      endcase
    end
    m_mag = (m_state == M_COOK) && ((m_nsec % DW) < m_pwr);
    p_startn = s_startn; p_stopn = s_stopn; p_clearn = s_clearn;
    p_pk = s_pk; p_key = s_keypad;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.so  = 4'(m_sec % 10);
    e.st  = 4'(m_sec / 10);
    e.mn  = {4'(m_min / 10), 4'(m_min % 10)};
    e.pw  = 4'(m_pwr);
    e.mag = m_mag & s_door;
    e.run = (m_state == M_COOK);
    e.dn  = (m_state == M_DONE);
    return e;
  endfunction

  // Apply staged inputs, queue the outputs expected for the edge just taken,
  // then advance the model across the coming edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = s_reset; startn = s_startn; stopn = s_stopn; clearn = s_clearn;
      door_closed = s_door; keypad = s_keypad; power_key = s_pk;
      sb.push_back(expect_now());
      model_step();
    end
  endtask

  task automatic key(input int d);
    s_keypad = 10'd1 << d; tick(1);
    s_keypad = 10'd0;      tick(1);
  endtask
  task automatic press_start();
    s_startn = 1'b0; tick(1); s_startn = 1'b1; tick(1);
  endtask
  task automatic press_stop();
    s_stopn = 1'b0; tick(1); s_stopn = 1'b1; tick(1);
  endtask
  task automatic press_clear();
    s_clearn = 1'b0; tick(1); s_clearn = 1'b1; tick(1);
  endtask
  task automatic press_pk();
    s_pk = 1'b1; tick(1); s_pk = 1'b0; tick(1);
  endtask

  // Monitor: every falling edge the DUT presents a settled output set.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {sec_ones, sec_tens, minutes, power_level, mag_on, running, done};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got so=%0d st=%0d min=%h pw=%0d mag=%b run=%b done=%b, want so=%0d st=%0d min=%h pw=%0d mag=%b run=%b done=%b",
                   $time, a.so, a.st, a.mn, a.pw, a.mag, a.run, a.dn,
                   e.so, e.st, e.mn, e.pw, e.mag, e.run, e.dn);
        end
      end
    end
  end

  initial begin
    int r, d;
    reset = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; keypad = 10'd0; power_key = 1'b0;
    model_step();
    tick(3);
    s_reset = 1'b0;
    tick(2);

    // 1:05 countdown
    key(1); key(0); key(5); press_start(); tick(30);
    // 0:03 at full power to completion, then a digit leaves DONE
    press_clear(); key(3); press_start(); tick(16);
    key(7); tick(2);
    // power 3 over two duty windows
    press_clear(); press_pk(); key(3); key(2); key(0); press_start(); tick(90);
    // door opened mid-second, then resumed
    press_clear(); key(5); press_start(); tick(2);
    s_door = 1'b0; tick(3); s_door = 1'b1; tick(2); press_start(); tick(10);
    // stop twice
    press_clear(); key(9); press_start(); tick(5); press_stop(); press_stop(); tick(2);
    // clear and start together
    key(5); s_clearn = 1'b0; s_startn = 1'b0; tick(1);
    s_clearn = 1'b1; s_startn = 1'b1; tick(3);
    // held start fires once
    press_clear(); key(2); key(0); s_startn = 1'b0; tick(50); s_startn = 1'b1; tick(5);
    // start at 0:00
    press_clear(); press_start(); tick(10); press_clear();
    // invalid multi-key, held key, power digit 0, 0:90 countdown
    s_keypad = 10'b0000000110; tick(1); s_keypad = 10'd0; tick(1);
    s_keypad = 10'd1 << 4; tick(5); s_keypad = 10'd0; tick(1);
    press_pk(); key(0); key(9); key(0); key(1); key(2); key(3); press_start(); tick(12);
    press_clear(); key(9); key(0); press_start(); tick(10);
    // done, then door opens
    press_clear(); key(1); press_start(); tick(8); s_door = 1'b0; tick(2); s_door = 1'b1; tick(2);
    // reset mid-cook
    key(4); press_start(); tick(6); s_reset = 1'b1; tick(1); s_reset = 1'b0; tick(3);

    // randomized traffic: at most one new press per cycle
    for (int c = 0; c < 12000; c++) begin
      s_reset = 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        s_startn = 1'b1; s_stopn = 1'b1; s_clearn = 1'b1; s_keypad = 10'd0; s_pk = 1'b0;
      end
      if (!s_door && $urandom_range(0, 3) == 0) s_door = 1'b1;
      r = $urandom_range(0, 299);
      if (r < 14) s_startn = 1'b0;
      else if (r < 18) s_stopn = 1'b0;
      else if (r < 21) s_clearn = 1'b0;
      else if (r < 70) begin
        d = $urandom_range(0, 9);
        if ($urandom_range(0, 9) == 0) s_keypad = (10'd1 << d) | (10'd1 << ((d + 1) % 10));
        else s_keypad = 10'd1 << d;
      end
      else if (r < 76) s_pk = 1'b1;
      else if (r < 78) s_door = 1'b0;
      else if (r == 78) s_reset = 1'b1;
      tick(1);
    end
    s_startn = 1'b1; s_stopn = 1'b1; s_clearn = 1'b1; s_keypad = 10'd0; s_pk = 1'b0;
    tick(2);

    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
